// File: rtl/etm_acc_18.sv
// Windowed accumulator for ETM multiplier products: sums ACC_LEN unsigned products
// modulo 2^18, flags any dropped carry, and hands the result off over valid/ready.

module rca_18bits (
  input  logic [17:0] i_a,
  input  logic [17:0] i_b,
  output logic [17:0] o_sum
);

  always_comb begin
    logic w_carry;
    w_carry = 1'b0;
    o_sum   = '0;
    for (int i = 0; i < 18; i++) begin
      o_sum[i] = i_a[i] ^ i_b[i] ^ w_carry;
      w_carry  = (i_a[i] & i_b[i]) | (w_carry & (i_a[i] ^ i_b[i]));
    end
  end

endmodule

module etm_acc_18 #(
  parameter int unsigned ACC_LEN = 9,
  parameter int unsigned IN_W    = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IN_W-1:0] in_prod,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [17:0]     out_sum,
  output logic            out_ovf
);

  typedef enum logic [1:0] {StIdle, StAcc, StDone} state_e;

  localparam logic [6:0] LenC = 7'(ACC_LEN);

  state_e      r_state, w_state;
  logic [17:0] r_acc, w_acc;
  logic        r_ovf, w_ovf;
  logic [6:0]  r_cnt, w_cnt;
  logic        r_out_valid, w_out_valid;
  logic [17:0] r_out_sum, w_out_sum;
  logic        r_out_ovf, w_out_ovf;
  // Holds in_ready low until the first clock edge after reset release.
  logic        r_live;

  logic [17:0] w_prod_ext;
  logic [17:0] w_add_sum;
  logic        w_carry17;
  logic        w_in_xfer;
  logic        w_out_xfer;
  logic [6:0]  w_cnt_inc;

  assign w_prod_ext = {{(18 - IN_W){1'b0}}, in_prod};

  rca_18bits u_rca (
    .i_a   (r_acc),
    .i_b   (w_prod_ext),
    .o_sum (w_add_sum)
  );

  // The adder has no carry out; a wrapped sum is smaller than the old accumulator.
  assign w_carry17  = (w_add_sum < r_acc);
  assign in_ready   = r_live && (r_state != StDone);
  assign w_in_xfer  = in_valid && in_ready;
  assign w_out_xfer = r_out_valid && out_ready;
  assign w_cnt_inc  = r_cnt + 7'd1;

  always_comb begin
    w_state     = r_state;
    w_acc       = r_acc;
    w_ovf       = r_ovf;
    w_cnt       = r_cnt;
    w_out_valid = r_out_valid;
    w_out_sum   = r_out_sum;
    w_out_ovf   = r_out_ovf;
    unique case (r_state)
      StIdle: begin
        if (w_in_xfer) begin
          w_acc   = w_prod_ext;
          w_ovf   = 1'b0;
          w_cnt   = 7'd1;
          w_state = StAcc;
        end
      end
      StAcc: begin
        if (w_in_xfer) begin
          w_acc = w_add_sum;
          w_ovf = r_ovf | w_carry17;
          w_cnt = w_cnt_inc;
          if (w_cnt_inc == LenC) begin
            w_state     = StDone;
            w_out_valid = 1'b1;
            w_out_sum   = w_add_sum;
            w_out_ovf   = r_ovf | w_carry17;
          end
        end
      end
      StDone: begin
        if (w_out_xfer) begin
          w_state     = StIdle;
          w_cnt       = 7'd0;
          w_out_valid = 1'b0;
        end
      end
      default: begin
        w_state     = StIdle;
        w_cnt       = 7'd0;
        w_out_valid = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StIdle;
      r_acc       <= '0;
      r_ovf       <= 1'b0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_ovf   <= 1'b0;
      r_live      <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_acc       <= w_acc;
      r_ovf       <= w_ovf;
      r_cnt       <= w_cnt;
      r_out_valid <= w_out_valid;
      r_out_sum   <= w_out_sum;
      r_out_ovf   <= w_out_ovf;
      r_live      <= 1'b1;
    end
  end

  assign out_valid = r_out_valid;
  assign out_sum   = r_out_sum;
  assign out_ovf   = r_out_ovf;

endmodule
